// File: rtl/video_copper.sv
// video_copper
//   Raster-synchronised register-write sequencer ("copper") plus the IO-write
//   arbiter in front of the video block's 4-bit register interface. Each frame
//   it runs a CPU-loaded program of up to 64 16-bit instructions:
//     bit15=0      WRITE  io addr = [11:8], data = [7:0]
//     bits15:14=10 WAIT   until vpos == [7:0]
//     bits15:14=11 END    halt until the next frame start
//   CPU IO accesses always win; a copper write stalls while the CPU bus is busy.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cop_enable                 run enable
//   vpos, vblank               raster position / vertical blank level
//   prog_addr/wrdata/wren      CPU byte port into program RAM (addr[0]=1 -> high byte)
//   prog_rddata                CPU program read data, 1-cycle latency, read-first
//   cpu_io_addr/wrdata/wren    CPU video IO write
//   cpu_io_rden                CPU video IO read in progress
//   vid_io_addr/wrdata/wren    muxed access to the video block
//   cop_busy                   high in FETCH/EXEC/WAIT
//   cop_pc                     current program counter
module video_copper (
  input  logic       clk,
  input  logic       reset,
  input  logic       cop_enable,
  input  logic [7:0] vpos,
  input  logic       vblank,
  input  logic [6:0] prog_addr,
  input  logic [7:0] prog_wrdata,
  input  logic       prog_wren,
  output logic [7:0] prog_rddata,
  input  logic [3:0] cpu_io_addr,
  input  logic [7:0] cpu_io_wrdata,
  input  logic       cpu_io_wren,
  input  logic       cpu_io_rden,
  output logic [3:0] vid_io_addr,
  output logic [7:0] vid_io_wrdata,
  output logic       vid_io_wren,
  output logic       cop_busy,
  output logic [5:0] cop_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  pc_reg, pc_next;
  logic [15:0] instr_reg;
  logic [7:0]  prog_rddata_reg;
  logic        vblank_prev_reg;
  logic        frame_start_reg;
  logic        cop_wr;
  logic        cop_wr_out;
  logic        cpu_active;
  logic        is_write;
  logic        is_wait;
  logic [1:0]  instr_unused;

  // Program RAM, split into byte lanes so the CPU byte writes map onto
  // plain single-lane writes.
  logic [7:0] mem_lo [0:63];
  logic [7:0] mem_hi [0:63];

  logic [5:0] prog_entry;
  assign prog_entry = prog_addr[6:1];

  always_ff @(posedge clk) begin
    if (prog_wren && !prog_addr[0]) begin
      mem_lo[prog_entry] <= prog_wrdata;
    end
    if (prog_wren && prog_addr[0]) begin
      mem_hi[prog_entry] <= prog_wrdata;
    end
  end

  // CPU read port: read-first, so a write to the same byte returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_rddata_reg <= 8'h00;
    end else begin
      prog_rddata_reg <= prog_addr[0] ? mem_hi[prog_entry] : mem_lo[prog_entry];
    end
  end

  // Copper read port: only loads in FETCH so the instruction stays stable
  // through EXEC stalls and WAIT even if the CPU rewrites that entry.
  always_ff @(posedge clk) begin
    if (state_reg == S_FETCH) begin
      instr_reg <= {mem_hi[pc_reg], mem_lo[pc_reg]};
    end
  end

  // Frame start detector. Reset samples the current vblank level so leaving
  // reset inside vblank does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_prev_reg <= vblank;
      frame_start_reg <= 1'b0;
    end else begin
      vblank_prev_reg <= vblank;
      frame_start_reg <= vblank & ~vblank_prev_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= 6'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  assign cpu_active   = cpu_io_wren | cpu_io_rden;
  assign is_write     = ~instr_reg[15];
  assign is_wait      = (instr_reg[15:14] == 2'b10);
  assign instr_unused = instr_reg[13:12];

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cop_wr     = 1'b0;
    if (!cop_enable) begin
      state_next = S_IDLE;
    end else if (frame_start_reg) begin
      // Frame start overrides everything, including a write due this cycle.
      state_next = S_FETCH;
      pc_next    = 6'd0;
    end else begin
      unique case (state_reg)
        S_IDLE: state_next = S_IDLE;
        S_FETCH: state_next = S_EXEC;
        S_EXEC: begin
          if (is_write) begin
            if (!cpu_active) begin
              cop_wr     = 1'b1;
              pc_next    = pc_reg + 6'd1;
              state_next = S_FETCH;
            end
          end else if (is_wait) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_HALT;
          end
        end
        S_WAIT: begin
          if (vpos == instr_reg[7:0]) begin
            pc_next    = pc_reg + 6'd1;
            state_next = S_FETCH;
          end
        end
        S_HALT: state_next = S_HALT;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Reset masks the strobe so a write pending in EXEC never leaks out.
  assign cop_wr_out = cop_wr & ~reset;

  assign vid_io_addr   = cop_wr_out ? instr_reg[11:8] : cpu_io_addr;
  assign vid_io_wrdata = cop_wr_out ? instr_reg[7:0]  : cpu_io_wrdata;
  assign vid_io_wren   = cop_wr_out | cpu_io_wren;

  assign prog_rddata = prog_rddata_reg;
  assign cop_busy    = (state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_WAIT);
  assign cop_pc      = pc_reg;

endmodule
